sect163k1_pt_chk: RTL and testbench
===================================

SECT163K1_PT_CHK -- requirements
Module: sect163k1_pt_chk

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-003 SHALL have port clr, input, 1: synchronous clear; aborts any check.
REQ-004 SHALL have port start, input, 1: single-cycle request; x, y sampled in the same cycle.
REQ-005 SHALL have port x, input, 163: affine x coordinate in GF(2^163), polynomial basis.
REQ-006 SHALL have port y, input, 163: affine y coordinate in GF(2^163), polynomial basis.
REQ-007 SHALL have port busy, output, 1: check in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the result is available.
REQ-009 SHALL have port valid, output, 1: the latched (x,y) satisfies y^2 + xy = x^3 + x^2 + 1; held until the next start.
REQ-010 SHALL have port inf, output, 1: the latched input was (0,0), meaning point at infinity; held until the next start.

Function
REQ-011 SHALL implement all field arithmetic modulo f(z) = z^163 + z^7 + z^6 + z^3 + 1, using sect163k1 curve constants a = 1, b = 1.
REQ-012 SHALL use FSM states IDLE, M_YY, M_XY, M_XX, M_XXX, CMP; the sequence is IDLE -> M_YY -> M_XY -> M_XX -> M_XXX -> CMP -> IDLE.
REQ-013 SHALL leave IDLE only on start=1, latching x and y into internal registers; busy SHALL rise in the following cycle.
REQ-014 SHALL make each M_* state issue one multiplication and occupy exactly 164 cycles: 1 load cycle plus 163 MSB-first bit-serial iterations.
REQ-015 SHALL compute y*y, x*y, x*x and (x*x)*x in that order; multiplication operands are the latched values only.
REQ-016 SHALL, in CMP, form lhs = yy XOR xy and rhs = xxx XOR xx XOR 1, then set valid = (lhs == rhs).
REQ-017 SHALL set inf = (x == 0 and y == 0) in CMP, and SHALL force valid = 0 whenever inf = 1.
REQ-018 SHALL pulse done exactly 658 cycles after the start-sampling edge; busy SHALL fall in the same cycle done is asserted.
REQ-019 SHALL ignore start while busy = 1; the check in progress and the latched inputs SHALL be unaffected.
REQ-020 SHALL accept a new start in the cycle done is high; that start SHALL begin a new check with no idle cycle.
REQ-021 SHALL, on clr=1 in any state, go to IDLE next cycle with busy = done = valid = inf = 0; clr SHALL override a simultaneous start.

Reset
REQ-022 SHALL, on rst=1, asynchronously force state IDLE, busy = 0, done = 0, valid = 0, inf = 0, and all datapath registers to 0.
REQ-023 SHALL, if rst asserts mid-check, abort that check so that no done pulse is produced for it.

Configuration
REQ-024 SHALL, with SECT163K1_PT_CHK_ERR_EN defined, add output port err (1 bit, reset 0) that pulses for one cycle when start=1 while busy=1.
REQ-025 SHALL, without SECT163K1_PT_CHK_ERR_EN, omit the err port; start while busy SHALL be silently ignored.

Structure
REQ-026 SHALL place the width constant (163), the reduction-polynomial constant, the curve constant b, and the FSM state enum in package sect163k1_pkg.
REQ-027 SHALL instantiate one sub-module, gf163_mul: a bit-serial GF(2^163) multiplier with start/done handshake and 164-cycle latency, reused for all four products.

Verification
REQ-028 Generator point check: x = 2FE13C0537BBC11ACAA07D793DE4E6D5E5C94EEE8, y = 289070FB05D38FF58321F2E800536D538CCDAA3D9 -> done at cycle 658, valid = 1, inf = 0.
REQ-029 Corrupted point check: same x, y with bit 0 flipped -> valid = 0, inf = 0.
REQ-030 Order-2 point and infinity: (0,1) -> valid = 1, inf = 0; (0,0) -> valid = 0, inf = 1.
REQ-031 Start while busy: start at cycle 0, then start again at cycle 100 with a different point -> single done at cycle 658 with the first point's result; err pulses at cycle 101 when SECT163K1_PT_CHK_ERR_EN is defined.
REQ-032 Abort mid-check: assert clr at cycle 300, and in a separate run assert rst at cycle 300 -> no done, all outputs 0; a following generator check passes.
REQ-033 Back-to-back starts: start issued in the done cycle -> second done exactly 658 cycles later with a correct result.

Source files
------------

// File: rtl/sect163k1_pkg.sv
// rtl/sect163k1_pkg.sv - shared constants, FSM state enum and field helper for the sect163k1 point check
package sect163k1_pkg;

    // Field width: elements of GF(2^163), polynomial basis.
    localparam int GF_W = 163;

    // Reduction polynomial f(z) = z^163 + z^7 + z^6 + z^3 + 1. The z^163 term is
    // implicit; only the low-order terms are stored.
    localparam logic [GF_W-1:0] GF_POLY_LOW = 163'hC9;

    // Curve constant b (a = 1 shows up as the x^2 term in the check).
    localparam logic [GF_W-1:0] CURVE_B = 163'd1;

    // Multiplier timing: one load cycle followed by GF_W iterations.
    localparam logic [7:0] MUL_ITER_LAST = 8'd162;
    localparam logic [7:0] STEP_LAST     = 8'd163;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        M_YY  = 3'd1,
        M_XY  = 3'd2,
        M_XX  = 3'd3,
        M_XXX = 3'd4,
        CMP   = 3'd5
    } state_t;

    // Multiply by z and reduce modulo f(z).
    function automatic logic [GF_W-1:0] gf_mulz(input logic [GF_W-1:0] a);
        return {a[GF_W-2:0], 1'b0} ^ (a[GF_W-1] ? GF_POLY_LOW : '0);
    endfunction

endpackage

// File: rtl/gf163_mul.sv
// rtl/gf163_mul.sv - bit-serial MSB-first GF(2^163) multiplier
//
// Purpose: computes o_p = i_a * i_b mod f(z). i_start loads the operands and
//          clears the accumulator; 163 iterations follow; o_done pulses in the
//          164th cycle after the i_start cycle, and o_p holds the product until
//          the next i_start.
// Ports:
//   i_clk, i_rst (async, active-high), i_clr (sync abort)
//   i_start        - load operands this cycle
//   i_a, i_b       - operands
//   o_p            - accumulator / product
//   o_done         - one-cycle pulse, o_p valid
module gf163_mul
    import sect163k1_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_start,
    input  logic [GF_W-1:0] i_a,
    input  logic [GF_W-1:0] i_b,
    output logic [GF_W-1:0] o_p,
    output logic            o_done
);

    logic [GF_W-1:0] r_a;
    logic [GF_W-1:0] r_b;
    logic [GF_W-1:0] r_acc;
    logic [GF_W-1:0] w_acc_nxt;
    logic [7:0]      r_cnt;
    logic            r_run;
    logic            r_done;

    // Horner step: acc = acc*z + a*b_i, scanning b from its top bit down.
    assign w_acc_nxt = gf_mulz(r_acc) ^ (r_b[GF_W-1] ? r_a : '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_clr) begin
                r_cnt <= '0;
                r_run <= 1'b0;
            end else if (i_start) begin
                r_a   <= i_a;
                r_b   <= i_b;
                r_acc <= '0;
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_acc <= w_acc_nxt;
                r_b   <= {r_b[GF_W-2:0], 1'b0};
                if (r_cnt == MUL_ITER_LAST) begin
                    r_cnt  <= '0;
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign o_p    = r_acc;
    assign o_done = r_done;

endmodule

// File: rtl/sect163k1_pt_chk.sv
// rtl/sect163k1_pt_chk.sv - checks that an affine point lies on sect163k1: y^2 + xy = x^3 + x^2 + 1
//
// Purpose: on start, latches (x,y) and runs four products through one shared
//          multiplier (yy, xy, xx, xxx), then compares both sides of the curve
//          equation. (0,0) is reported as the point at infinity.
// Ports:
//   clk, rst (async, active-high), clr (sync abort, wins over start)
//   start          - one-cycle request, x/y sampled with it
//   x, y           - affine coordinates
//   busy           - check in progress (falls together with done)
//   done           - one-cycle result pulse
//   valid, inf     - result flags, held until the next start
//   err            - only with SECT163K1_PT_CHK_ERR_EN: pulses on start while busy
module sect163k1_pt_chk
    import sect163k1_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            start,
    input  logic [GF_W-1:0] x,
    input  logic [GF_W-1:0] y,
    output logic            busy,
    output logic            done,
    output logic            valid,
    output logic            inf
`ifdef SECT163K1_PT_CHK_ERR_EN
    ,
    output logic            err
`endif
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic [GF_W-1:0] r_x;
    logic [GF_W-1:0] r_y;
    logic [GF_W-1:0] r_yy;
    logic [GF_W-1:0] r_xy;
    logic [GF_W-1:0] r_xx;
    logic            r_done;
    logic            r_valid;
    logic            r_inf;

    logic            w_mul_start;
    logic [GF_W-1:0] w_mul_a;
    logic [GF_W-1:0] w_mul_b;
    logic [GF_W-1:0] w_mul_p;
    logic            w_mul_done;
    logic            w_step_last;
    logic [GF_W-1:0] w_lhs;
    logic [GF_W-1:0] w_rhs;
    logic            w_is_inf;

    assign w_step_last = (r_cnt == STEP_LAST);

    gf163_mul u_mul (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (clr),
        .i_start (w_mul_start),
        .i_a     (w_mul_a),
        .i_b     (w_mul_b),
        .o_p     (w_mul_p),
        .o_done  (w_mul_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Each M_* state loads the multiplier in its first cycle; the previous
    // product completes in that same cycle, so M_XXX can feed xx straight
    // from the multiplier output.
    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_mul_a     = r_y;
        w_mul_b     = r_y;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_nxt = M_YY;
            end
            M_YY: begin
                w_mul_start = (r_cnt == 8'd0);
                if (w_step_last) w_state_nxt = M_XY;
            end
            M_XY: begin
                w_mul_start = (r_cnt == 8'd0);
                w_mul_a     = r_x;
                if (w_step_last) w_state_nxt = M_XX;
            end
            M_XX: begin
                w_mul_start = (r_cnt == 8'd0);
                w_mul_a     = r_x;
                w_mul_b     = r_x;
                if (w_step_last) w_state_nxt = M_XXX;
            end
            M_XXX: begin
                w_mul_start = (r_cnt == 8'd0);
                w_mul_a     = w_mul_p;
                w_mul_b     = r_x;
                if (w_step_last) w_state_nxt = CMP;
            end
            CMP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (clr) w_state_nxt = IDLE;
    end

    // In CMP the multiplier output holds x^3.
    assign w_lhs    = r_yy ^ r_xy;
    assign w_rhs    = w_mul_p ^ r_xx ^ CURVE_B;
    assign w_is_inf = (r_x == '0) && (r_y == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_yy    <= '0;
            r_xy    <= '0;
            r_xx    <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_inf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_inf   <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_x     <= x;
                            r_y     <= y;
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_inf   <= 1'b0;
                        end
                    end
                    M_YY, M_XY, M_XX, M_XXX: begin
                        r_cnt <= w_step_last ? 8'd0 : r_cnt + 8'd1;
                        if (w_mul_done) begin
                            if (r_state == M_XY)  r_yy <= w_mul_p;
                            if (r_state == M_XX)  r_xy <= w_mul_p;
                            if (r_state == M_XXX) r_xx <= w_mul_p;
                        end
                    end
                    CMP: begin
                        r_valid <= (w_lhs == w_rhs) && !w_is_inf;
                        r_inf   <= w_is_inf;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign valid = r_valid;
    assign inf   = r_inf;

`ifdef SECT163K1_PT_CHK_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= start && busy && !clr;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_sect163k1_pt_chk.sv
// tb/tb_sect163k1_pt_chk.sv - scoreboard bench for sect163k1_pt_chk
module tb_sect163k1_pt_chk;

    localparam logic [162:0] GX = 163'h2FE13C0537BBC11ACAA07D793DE4E6D5E5C94EEE8;
    localparam logic [162:0] GY = 163'h289070FB05D38FF58321F2E800536D538CCDAA3D9;
    localparam int LAT = 658;

    typedef struct {
        logic valid;
        logic inf;
        int   cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic [162:0] x = '0;
    logic [162:0] y = '0;
    logic         busy;
    logic         done;
    logic         valid;
    logic         inf;
`ifdef SECT163K1_PT_CHK_ERR_EN
    logic         err;
`endif

    sect163k1_pt_chk dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .inf   (inf)
`ifdef SECT163K1_PT_CHK_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    exp_t sb_q[$];
    exp_t m_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_e = sb_q.pop_front();
                check("done_cycle", cyc, m_e.cyc);
                check("valid", {31'd0, valid}, {31'd0, m_e.valid});
                check("inf", {31'd0, inf}, {31'd0, m_e.inf});
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called just after a rising edge; returns one cycle later with start low.
    task automatic drive_start(input logic [162:0] px, input logic [162:0] py,
                               input logic ev, input logic ei, input bit expect_done,
                               output int s);
        exp_t e;
        start = 1'b1;
        x     = px;
        y     = py;
        s     = cyc;
        if (expect_done) begin
            e.valid = ev;
            e.inf   = ei;
            e.cyc   = s + LAT;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", sb_q.size(), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_done"},  {31'd0, done},  32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_inf"},   {31'd0, inf},   32'd0);
    endtask

    task automatic run_point(input logic [162:0] px, input logic [162:0] py,
                             input logic ev, input logic ei);
        int s;
        drive_start(px, py, ev, ei, 1'b1, s);
        check("busy_rise", {31'd0, busy}, 32'd1);
        wait_drain(LAT + 20);
    endtask

    initial begin
        int s;
        int nd;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        // Directed points: generator, corrupted, order-2, infinity, off-curve, -G.
        run_point(GX, GY, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("valid_hold", {31'd0, valid}, 32'd1);
        run_point(GX, GY ^ 163'd1, 1'b0, 1'b0);
        run_point(163'd0, 163'd1, 1'b1, 1'b0);
        run_point(163'd0, 163'd0, 1'b0, 1'b1);
        run_point(163'd0, 163'd2, 1'b0, 1'b0);
        run_point(163'd1, 163'd5, 1'b0, 1'b0);
        run_point(GX, GX ^ GY, 1'b1, 1'b0);

        // Start while busy is ignored; result and timing belong to the first point.
        drive_start(GX, GY, 1'b1, 1'b0, 1'b1, s);
        goto(s + 100);
        start = 1'b1;
        x     = '0;
        y     = '0;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef SECT163K1_PT_CHK_ERR_EN
        @(negedge clk);
        check("err_pulse", {31'd0, err}, 32'd1);
        @(negedge clk);
        check("err_single", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
`endif
        wait_drain(LAT + 20);

        // clr wins over a simultaneous start.
        clr   = 1'b1;
        start = 1'b1;
        x     = GX;
        y     = GY;
        @(posedge clk); #1;
        clr   = 1'b0;
        start = 1'b0;
        check_idle_outputs("clr_vs_start");

        // clr mid-check: abort, no done.
        drive_start(GX, GY, 1'b1, 1'b0, 1'b0, s);
        goto(s + 300);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check_idle_outputs("clr_abort");
        nd = n_done;
        repeat (LAT + 20) @(posedge clk);
        #1;
        check("clr_no_done", n_done, nd);
        run_point(GX, GY, 1'b1, 1'b0);

        // rst mid-check: asynchronous abort, no done.
        drive_start(GX, GY, 1'b1, 1'b0, 1'b0, s);
        goto(s + 300);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst_abort");
        @(posedge clk); #1;
        rst = 1'b0;
        nd = n_done;
        repeat (LAT + 20) @(posedge clk);
        #1;
        check("rst_no_done", n_done, nd);
        run_point(GX, GY, 1'b1, 1'b0);

        // Back-to-back: second start in the done cycle.
        drive_start(GX, GY, 1'b1, 1'b0, 1'b1, s);
        goto(s + LAT);
        check("b2b_done_now", {31'd0, done}, 32'd1);
        drive_start(GX, GX ^ GY, 1'b1, 1'b0, 1'b1, s);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_drain(2 * LAT + 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
